dm_wait_mem: RTL and testbench
==============================

// Module: dm_wait_mem
// PURPOSE
//  Parametrised data memory for the next-generation MIPS core.
//  - Executes all DMType load/store widths: word, signed/unsigned half, signed/unsigned byte.
//  - Adds a valid/ready request handshake and configurable access latency.
//  - Uses a response handshake and flags misaligned or out-of-range accesses.
//  - Sits between the datapath MEM stage and the storage array; the core stalls on req_ready/resp_valid.
// PARAMETERS
//  DEPTH        1024          number of 32-bit words; power of two, 16..65536
//  WAIT_CYCLES  2             extra access latency in cycles, 0..15
//  BASE_ADDR    32'h0000_0000 byte address of word 0; must be DEPTH*4-aligned
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   block accepts request this cycle
//  req_we      in   1   1 = store, 0 = load
//  req_type    in   3   DMType: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; the low bits are used for half/byte stores
//  resp_valid  out  1   response available
//  resp_ready  in   1   consumer takes response
//  resp_rdata  out  32  load result, extended per req_type; 0 for stores and errors
//  resp_err    out  1   1 = misaligned, out-of-range, or req_type 101..111
//  busy        out  1   FSM not in IDLE
// BEHAVIOUR
//  States:
//  - IDLE: req_ready=1. On req_valid: latch we/type/addr/wdata and check for errors.
//    Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
//  - WAIT: load counter with WAIT_CYCLES-1; decrement each cycle; at 0 go to ACCESS.
//  - ACCESS: one cycle.
//    - Store without error: write byte lanes at this edge.
//      word writes all 4 bytes; half writes addr[1]-selected pair; byte writes addr[1:0]-selected lane (little-endian).
//    - Load without error: register the extended read data.
//    - Error: no write; rdata=0.
//    Then go to RESP.
//  - RESP: resp_valid=1 with resp_rdata/resp_err stable. Go to IDLE when resp_ready=1.
//  Timing:
//  - Request accepted at edge N; resp_valid rises after edge N+WAIT_CYCLES+1.
//  - A store becomes visible to a load accepted after the store's RESP completes.
//  Handshake:
//  - req_ready=0 outside IDLE; inputs are ignored while not ready.
//  - resp_valid stays high until resp_ready is sampled high.
//  - resp_ready with resp_valid=0 is ignored.
//  - Request and response cannot overlap; no back-to-back acceptance.
//  Error checks, evaluated on latched values:
//  - misaligned: word with addr[1:0]!=0, or half with addr[0]!=0;
//  - out of range: (addr-BASE_ADDR) >= DEPTH*4, computed in 33 bits;
//  - req_type > 100.
//  Extension: half signed replicates bit 15; byte signed replicates bit 7; unsigned types zero-fill.
//  Reset (reset=0, asynchronous):
//  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, req_ready=1;
//  - all memory words cleared to 0.
//  - Reset mid-operation: the in-flight request is dropped and a pending store is not performed.
//  Boundaries:
//  - Highest word (BASE_ADDR+DEPTH*4-4) is legal; one word beyond it errors.
//  - Address wrap below BASE_ADDR errors (subtraction borrow).
// TESTING
//  - WAIT_CYCLES=2: store word 0xDEADBEEF at 0x10, then load word 0x10.
//    -> resp_valid 3 cycles after each accept; rdata=0xDEADBEEF, err=0.
//  - After that, store byte 0x80 at 0x12, then load 0x12 signed/unsigned byte, then load word 0x10.
//    -> 0xFFFFFF80, 0x00000080, 0xDE80BEEF.
//  - Store half 0x8001 at 0x16; load signed half 0x16 -> 0xFFFF8001.
//    Load half at 0x15, or word at 0x1A -> err=1, rdata=0, memory unchanged.
//  - DEPTH=1024, BASE_ADDR=0: load word 0xFFC -> err=0; load word 0x1000 -> err=1.
//    req_type=3'b111 -> err=1.
//  - Hold resp_ready=0 for 5 cycles -> resp_valid and data held, req_ready=0.
//    req_valid pulses during the hold are ignored; resp_ready=1 -> IDLE next cycle.
//  - Assert reset in WAIT of a store to 0x20 -> outputs at reset values immediately.
//    A subsequent load of 0x20 returns 0. WAIT_CYCLES=0 -> response 1 cycle after accept.

Source files
------------

// File: rtl/dm_wait_mem.sv
// Data memory for the MIPS MEM stage: valid/ready request, configurable latency,
// DMType load/store widths, registered response with misalignment/range/type error flag.
module dm_wait_mem #(
   parameter int          DEPTH       = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [32:0] SPAN      = 33'(DEPTH) * 33'd4;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   state_t        state, next_state;
   logic          lat_we;
   logic [2:0]    lat_type;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic [3:0]    cnt;
   logic [31:0]   mem [DEPTH];

   logic [32:0]   offset;
   logic          misalign, range_err, type_err, err;
   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word, load_val, wr_data;
   logic [7:0]    byte_val;
   logic [15:0]   half_val;
   logic [3:0]    be;

   // Borrow from the 33-bit subtraction makes addresses below BASE_ADDR land out of range.
   always_comb begin
      offset    = {1'b0, lat_addr} - {1'b0, BASE_ADDR};
      range_err = offset >= SPAN;
      misalign  = ((lat_type == 3'b000) && (lat_addr[1:0] != 2'b00)) ||
                  (((lat_type == 3'b001) || (lat_type == 3'b010)) && lat_addr[0]);
      type_err  = lat_type > 3'b100;
      err       = range_err || misalign || type_err;
      word_idx  = offset[AW+1:2];
      rd_word   = mem[word_idx];
      byte_val  = rd_word[{lat_addr[1:0], 3'b000} +: 8];
      half_val  = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
   end

   always_comb begin
      load_val = rd_word;
      wr_data  = lat_wdata;
      be       = 4'b1111;
      case (lat_type)
         3'b001: begin
            load_val = {{16{half_val[15]}}, half_val};
            wr_data  = {2{lat_wdata[15:0]}};
            be       = lat_addr[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            load_val = {16'h0000, half_val};
            wr_data  = {2{lat_wdata[15:0]}};
            be       = lat_addr[1] ? 4'b1100 : 4'b0011;
         end
         3'b011: begin
            load_val = {{24{byte_val[7]}}, byte_val};
            wr_data  = {4{lat_wdata[7:0]}};
            be       = 4'b0001 << lat_addr[1:0];
         end
         3'b100: begin
            load_val = {24'h000000, byte_val};
            wr_data  = {4{lat_wdata[7:0]}};
            be       = 4'b0001 << lat_addr[1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      busy       = (state != IDLE);
      resp_valid = (state == RESP);
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
         end
         WAIT:    if (cnt == 4'd0) next_state = ACCESS;
         ACCESS:  next_state = RESP;
         RESP:    if (resp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_we     <= 1'b0;
         lat_type   <= 3'b000;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         cnt        <= 4'd0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               lat_we    <= req_we;
               lat_type  <= req_type;
               lat_addr  <= req_addr;
               lat_wdata <= req_wdata;
               cnt       <= WAIT_LOAD;
            end
            WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            ACCESS: begin
               resp_err   <= err;
               resp_rdata <= (err || lat_we) ? 32'h0 : load_val;
            end
            default: ;
         endcase
      end
   end

   // Whole array clears on reset, so a store caught mid-flight by reset never lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if ((state == ACCESS) && lat_we && !err) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_dm_wait_mem.sv
// Directed bench for dm_wait_mem: table of load/store transactions with hand-computed
// results, plus handshake-hold, mid-flight reset and zero-latency sequences.
module tb_dm_wait_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, resp_ready;
   logic [2:0]  req_type;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata;

   logic        req_valid0;
   logic        resp_ready0 = 1'b1;
   logic        req_ready0, resp_valid0, resp_err0, busy0;
   logic [31:0] resp_rdata0;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   dm_wait_mem #(.DEPTH(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .busy(busy)
   );

   dm_wait_mem #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we), .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_rdata(resp_rdata0),
      .resp_err(resp_err0), .busy(busy0)
   );

   typedef struct {
      logic        we;
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [19];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Issues one request, measures accept-to-response latency, then consumes the response.
   task automatic applyStimulus(input string name, input logic we, input logic [2:0] typ,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      req_we    = we;
      req_type  = typ;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      checkOutput({name, " ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (resp_valid) begin
            lat = i;
            break;
         end
      end
      checkOutput({name, " latency"}, 32'(lat), 32'd3);
      checkOutput({name, " rdata"}, resp_rdata, exp_rdata);
      checkOutput({name, " err"}, 32'(resp_err), 32'(exp_err));
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checkOutput({name, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 3'b000, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 3'b000, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 3'b011, 32'h12,   32'h00000080, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 3'b011, 32'h12,   32'h0,        32'hFFFFFF80, 1'b0};
      vecs[4]  = '{1'b0, 3'b100, 32'h12,   32'h0,        32'h00000080, 1'b0};
      vecs[5]  = '{1'b0, 3'b000, 32'h10,   32'h0,        32'hDE80BEEF, 1'b0};
      vecs[6]  = '{1'b1, 3'b001, 32'h16,   32'h00008001, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 3'b001, 32'h16,   32'h0,        32'hFFFF8001, 1'b0};
      vecs[8]  = '{1'b0, 3'b010, 32'h16,   32'h0,        32'h00008001, 1'b0};
      vecs[9]  = '{1'b0, 3'b001, 32'h15,   32'h0,        32'h0,        1'b1};
      vecs[10] = '{1'b0, 3'b000, 32'h1A,   32'h0,        32'h0,        1'b1};
      vecs[11] = '{1'b1, 3'b000, 32'h15,   32'h12345678, 32'h0,        1'b1};
      vecs[12] = '{1'b0, 3'b000, 32'h14,   32'h0,        32'h80010000, 1'b0};
      vecs[13] = '{1'b0, 3'b000, 32'hFFC,  32'h0,        32'h0,        1'b0};
      vecs[14] = '{1'b0, 3'b000, 32'h1000, 32'h0,        32'h0,        1'b1};
      vecs[15] = '{1'b0, 3'b111, 32'h10,   32'h0,        32'h0,        1'b1};
      vecs[16] = '{1'b1, 3'b000, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0};
      vecs[17] = '{1'b0, 3'b000, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0};
      vecs[18] = '{1'b1, 3'b100, 32'h11,   32'hFFFFFFAB, 32'h0,        1'b0};

      reset = 1'b0;
      req_valid = 1'b0; req_valid0 = 1'b0; resp_ready = 1'b0;
      req_we = 1'b0; req_type = 3'b000; req_addr = '0; req_wdata = '0;
      #12;
      checkOutput("reset req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset rdata", resp_rdata, 32'h0);
      checkOutput("reset err", 32'(resp_err), 32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 19; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].typ, vecs[i].addr,
                       vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

      // Response held for five cycles while stray requests are offered.
      req_we = 1'b0; req_type = 3'b000; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("hold%0d valid", i), 32'(resp_valid), 32'd1);
         checkOutput($sformatf("hold%0d rdata", i), resp_rdata, 32'hDE80ABEF);
         checkOutput($sformatf("hold%0d ready", i), 32'(req_ready), 32'd0);
         req_valid = 1'b1; req_addr = 32'h20;
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checkOutput("hold release busy", 32'(busy), 32'd0);
      checkOutput("hold release ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      checkOutput("hold no stray accept", 32'(busy), 32'd0);

      // Reset while a store sits in WAIT.
      req_we = 1'b1; req_type = 3'b000; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("midreset in wait", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset ready", 32'(req_ready), 32'd1);
      checkOutput("midreset valid", 32'(resp_valid), 32'd0);
      checkOutput("midreset rdata", resp_rdata, 32'h0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      applyStimulus("after reset 0x20", 1'b0, 3'b000, 32'h20, 32'h0, 32'h0, 1'b0);
      applyStimulus("after reset 0x10", 1'b0, 3'b000, 32'h10, 32'h0, 32'h0, 1'b0);

      // Zero-latency instance: response one cycle after acceptance.
      req_we = 1'b0; req_type = 3'b000; req_addr = 32'h10; req_valid0 = 1'b1;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      checkOutput("w0 not yet valid", 32'(resp_valid0), 32'd0);
      @(posedge clk); #1;
      checkOutput("w0 valid", 32'(resp_valid0), 32'd1);
      checkOutput("w0 rdata", resp_rdata0, 32'h0);
      checkOutput("w0 err", 32'(resp_err0), 32'd0);
      @(posedge clk); #1;
      checkOutput("w0 idle", 32'(busy0), 32'd0);

      $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
